// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_fifo                                                 |
// | Description : Byte FIFO feeding an 8-bit UART transmitter (8N1 by default).|
// |               Define UART_TX_PARITY_EN to insert an even-parity bit (8E1). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_tx_fifo #(
  parameter int CLK_DIV = 868,
  parameter int FIFO_AW = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] uart_data,
  input  logic       uart_data_write,
  output logic       uart_tx_ready,
  output logic       uart_txd,
  output logic       tx_busy,
  output logic       tx_overflow
);

  localparam int               DEPTH     = 2 ** FIFO_AW;
  localparam logic [15:0]      BAUD_LAST = 16'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0] PTR_ONE   = (FIFO_AW + 1)'(1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd4
  } state_t;
`endif

  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wptr;
  logic [FIFO_AW:0] rptr;
  logic             full;
  logic             empty;
  logic             wr_en;
  logic [7:0]       head;

  state_t           state;
  state_t           next_state;
  logic             pop;
  logic             baud_tick;
  logic [15:0]      baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
`ifdef UART_TX_PARITY_EN
  logic             parity_bit;
`endif

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full          = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                         (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
  assign empty         = (wptr == rptr);
  // Ready comes only from pointer flops, so a pop in the same cycle cannot rescue a write.
  assign uart_tx_ready = !full;
  assign wr_en         = uart_data_write && !full && !rst;
  assign head          = mem[rptr[FIFO_AW-1:0]];
  assign baud_tick     = (baud_cnt == BAUD_LAST);
  assign tx_busy       = (state != IDLE) || !empty;

  // Byte storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr[FIFO_AW-1:0]] <= uart_data;
    end
  end

  // Write/read pointers and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + PTR_ONE;
      end
      if (pop) begin
        rptr <= rptr + PTR_ONE;
      end
      if (uart_data_write && full) begin
        tx_overflow <= 1'b1;
      end
    end
  end

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; the FIFO head is popped only from IDLE.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          next_state = START;
        end
      end
      START: begin
        if (baud_tick) next_state = DATA;
      end
      DATA: begin
        if (baud_tick && (bit_cnt == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          next_state = PARITY;
`else
          next_state = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_tick) next_state = STOP;
      end
`endif
      STOP: begin
        if (baud_tick) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Baud/bit counters, shift register and the flopped serial output (one cycle behind state).
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      uart_txd   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      if ((state == IDLE) || baud_tick) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 16'd1;
      end

      if (pop) begin
        shreg      <= head;
        bit_cnt    <= '0;
`ifdef UART_TX_PARITY_EN
        parity_bit <= ^head;
`endif
      end else if ((state == DATA) && baud_tick) begin
        shreg   <= {1'b0, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end

      case (state)
        IDLE:    uart_txd <= 1'b1;
        START:   uart_txd <= 1'b0;
        DATA:    uart_txd <= shreg[0];
`ifdef UART_TX_PARITY_EN
        PARITY:  uart_txd <= parity_bit;
`endif
        default: uart_txd <= 1'b1;
      endcase
    end
  end

endmodule
`default_nettype wire
